// File: rtl/cal_sync_fifo.sv
// Parametrised single-clock FIFO with inferred RAM, 1- or 2-cycle read latency,
// occupancy count, almost-full/almost-empty thresholds and sticky error flags.
module cal_sync_fifo #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 128,
  parameter int PIPE      = 1,
  parameter int AFULL_TH  = DEPTH - 4,
  parameter int AEMPTY_TH = 4
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       wen_i,
  input  logic                       ren_i,
  input  logic                       err_clr_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       rvalid_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       afull_o,
  output logic                       aempty_o,
  output logic                       overflow_o,
  output logic                       underflow_o
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_C   = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] AEMPTY_C  = (AW+1)'(AEMPTY_TH);
  localparam logic        AFULL_RST = (AFULL_TH <= 0);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, empty_q, afull_q, aempty_q;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             wr_ok, rd_ok;
  logic [WIDTH-1:0] rdata_q;
  logic             rvalid_q;

  // Full/empty come from registered state only, so a write never passes straight to a read.
  always_comb begin
    wr_ok   = wen_i & ~full_q & ~flush_i;
    rd_ok   = ren_i & ~empty_q & ~flush_i;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_ok) wptr_d = wptr_q + 1'b1;
      if (rd_ok) rptr_d = rptr_q + 1'b1;
      if (wr_ok && !rd_ok)      count_d = count_q + 1'b1;
      else if (rd_ok && !wr_ok) count_d = count_q - 1'b1;
    end
    ovf_d = (wen_i & full_q & ~flush_i) | (ovf_q & ~err_clr_i);
    udf_d = (ren_i & empty_q & ~flush_i) | (udf_q & ~err_clr_i);
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= AFULL_RST;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == DEPTH_C);
      empty_q  <= (count_d == '0);
      afull_q  <= (count_d >= AFULL_C);
      aempty_q <= (count_d <= AEMPTY_C);
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // RAM array has no reset so it maps onto block memory.
  always_ff @(posedge clock_i) begin
    if (wr_ok) mem_q[wptr_q] <= wdata_i;
  end

  generate
    if (PIPE == 0) begin : g_lat1
      always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rvalid_q <= rd_ok;
          if (rd_ok) rdata_q <= mem_q[rptr_q];
        end
      end
    end else begin : g_lat2
      logic [WIDTH-1:0] ram_dout_q;
      logic             ram_vld_q;

      always_ff @(posedge clock_i) begin
        if (rd_ok) ram_dout_q <= mem_q[rptr_q];
      end

      // A flush kills the word sitting in the RAM output stage as well.
      always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
          ram_vld_q <= 1'b0;
          rdata_q   <= '0;
          rvalid_q  <= 1'b0;
        end else begin
          ram_vld_q <= rd_ok;
          rvalid_q  <= ram_vld_q & ~flush_i;
          if (ram_vld_q && !flush_i) rdata_q <= ram_dout_q;
        end
      end
    end
  endgenerate

  assign rdata_o     = rdata_q;
  assign rvalid_o    = rvalid_q;
  assign count_o     = count_q;
  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign afull_o     = afull_q;
  assign aempty_o    = aempty_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = udf_q;

endmodule

// File: doc/cal_sync_fifo.md
Name: cal_sync_fifo

Overview:
Parametrised single-clock FIFO with an inferred RAM, for buffering calibration and averaging data between pipeline stages. It replaces fixed 32x128 controller-plus-RAM instances. It adds configurable width and depth, 1- or 2-cycle read latency with a valid strobe, occupancy count, almost-full and almost-empty thresholds, synchronous flush, and sticky overflow/underflow error flags.

Parameters:
WIDTH, 32, data width in bits (1..72).
DEPTH, 128, number of entries; power of two, 4..4096; AW = log2(DEPTH).
PIPE, 1, read-data output register: 0 = 1-cycle read latency, 1 = 2-cycle read latency.
AFULL_TH, DEPTH-4, AFULL asserts when COUNT >= AFULL_TH.
AEMPTY_TH, 4, AEMPTY asserts when COUNT <= AEMPTY_TH.

Ports:
CLOCK  in  1  single clock; all logic on the rising edge.
RESET  in  1  asynchronous, active-high reset.
FLUSH  in  1  synchronous clear of pointers, count and read pipeline.
WDATA  in  WIDTH  write data.
WEN  in  1  write request.
REN  in  1  read request.
RDATA  out  WIDTH  read data; qualified by RVALID.
RVALID  out  1  RDATA holds the word popped 1+PIPE cycles earlier.
COUNT  out  AW+1  number of stored words (0..DEPTH).
FULL  out  1  COUNT == DEPTH.
EMPTY  out  1  COUNT == 0.
AFULL  out  1  COUNT >= AFULL_TH.
AEMPTY  out  1  COUNT <= AEMPTY_TH.
OVERFLOW  out  1  sticky: a write was attempted while full.
UNDERFLOW  out  1  sticky: a read was attempted while empty.
ERR_CLR  in  1  synchronous clear of OVERFLOW and UNDERFLOW.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: RDATA=0, RVALID=0, COUNT=0, EMPTY=1, FULL=0, AFULL=0, AEMPTY=1, OVERFLOW=0, UNDERFLOW=0.
- Reset mid-operation: pointers and count go to 0 and in-flight reads are discarded (RVALID drops immediately). RAM contents are not cleared.
- Pointers: AW-bit write and read pointers that wrap naturally from DEPTH-1 to 0. COUNT is held as a separate AW+1 register.
- Write acceptance: wr_ok = WEN & !FULL. On wr_ok, RAM[wptr] <= WDATA and wptr increments.
- Write while full: WEN & FULL is ignored; OVERFLOW is set on the next edge.
- Read acceptance: rd_ok = REN & !EMPTY. On rd_ok, RAM is read at rptr and rptr increments.
- Read while empty: REN & EMPTY is ignored; UNDERFLOW is set on the next edge.
- Full and empty are decided on registered state only. There is no write-through:
  - at EMPTY, simultaneous WEN+REN accepts the write, rejects the read and sets UNDERFLOW;
  - at FULL, simultaneous WEN+REN accepts the read, rejects the write and sets OVERFLOW.
- COUNT update: +1 on wr_ok only; -1 on rd_ok only; unchanged when both or neither.
- Flags: FULL, EMPTY, AFULL and AEMPTY are registered and consistent with COUNT in the same cycle.
- Read latency with PIPE=0: RDATA and RVALID update on the edge after rd_ok.
- Read latency with PIPE=1: RAM output register, then output register; RVALID is high 2 edges after rd_ok.
- RDATA holds its last value when RVALID=0. Back-to-back reads produce back-to-back RVALID.
- FLUSH: on the next edge, pointers and COUNT go to 0, the RVALID pipeline clears and flags return to their reset values except OVERFLOW/UNDERFLOW. FLUSH wins over a same-cycle WEN/REN, which are dropped without raising error flags.
- ERR_CLR: clears both sticky flags on the next edge. A same-cycle new error takes priority, so the flag remains set.
- Read-during-write to the same address cannot occur, because full and empty gating prevents it.

Test Plan:
- Fill and drain, DEPTH=128, PIPE=1: write 0..127 on consecutive cycles -> FULL=1 and COUNT=128 after the 128th edge. Then REN for 128 cycles -> RDATA 0..127 in order, RVALID 2 cycles after each REN, and EMPTY=1 at the end.
- Wrap-around, DEPTH=8, PIPE=0: run 20 cycles with sustained WEN+REN after preloading 3 words -> COUNT stays at 3, output is in order across pointer wrap, and each RVALID arrives 1 cycle after its REN.
- Boundary errors:
  - REN at EMPTY -> UNDERFLOW=1, no RVALID;
  - WEN+REN at EMPTY -> COUNT=1, UNDERFLOW=1;
  - WEN at FULL -> OVERFLOW=1, COUNT stays at DEPTH;
  - ERR_CLR -> both flags 0 on the next cycle.
- Thresholds, DEPTH=16, AFULL_TH=12, AEMPTY_TH=4:
  - AEMPTY deasserts when COUNT reaches 5;
  - AFULL asserts exactly when COUNT reaches 12;
  - both flags follow COUNT on the way down.
- FLUSH mid-read, PIPE=1: with 10 words stored, REN then FLUSH on the next cycle -> no RVALID emitted, COUNT=0 and EMPTY=1. New writes after the flush read back correctly from address 0.
- Async reset: assert RESET between clock edges with 5 words stored and a read in flight -> all outputs take their reset values immediately, and the FIFO operates normally after RESET deasserts.
